operand_negate_unit: RTL and testbench
======================================

# operand_negate_unit

Parametrised multi-cycle two's-complement stage between the operand decoder and the ALU of the calculator datapath. Accepts a coded word (two W-bit operands plus an opcode) over a valid/ready handshake. Per operand, it passes, negates or takes the absolute value, processing CHUNK bits per cycle with a ripple carry held in a register. It presents both results and the opcode with per-operand overflow flags until the consumer takes them.

## Interface
Parameters:
- W, 8, operand width; W >= 2
- OPC_W, 4, opcode width
- CHUNK, 2, bits converted per cycle; must divide W (N = W/CHUNK conversion cycles)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  producer has a coded word
- in_ready  out  1  block can accept; high only in IDLE and when rst is low
- nr_coded  in  2W+OPC_W  {first operand [2W+OPC_W-1:W+OPC_W], second operand [W+OPC_W-1:OPC_W], opcode [OPC_W-1:0]}
- mode_a  in  2  first-operand mode: 00 pass, 01 negate, 10 absolute, 11 pass
- mode_b  in  2  second-operand mode, same encoding
- out_valid  out  1  results valid (DONE state)
- out_ready  in  1  consumer takes results
- first_nr  out  W  converted first operand
- second_nr  out  W  converted second operand
- operation  out  OPC_W  opcode carried through unchanged
- ovf_a, ovf_b  out  1  overflow on the corresponding operand
- busy  out  1  state != IDLE

## Operation
- States: IDLE, CONV, DONE.
- IDLE → CONV on in_valid & in_ready.
  - Latch both operands, the opcode and the modes into working registers.
  - Per-operand negate flag: 0 for pass, 1 for negate, MSB of operand for absolute.
  - Chunk counter = 0; carry register per operand = 1.
- CONV, each cycle, chunk k (bits [k·CHUNK +: CHUNK], LSB first):
  - Negating operand: chunk = ~chunk + carry; carry-out is stored.
  - Non-negating operand: chunk is copied.
  - Counter increments. On the last chunk, final results go to the output registers and the state moves to DONE.
- Overflow: set when the negate flag is 1 and the operand is 1 followed by W-1 zeros (most-negative value). Result wraps to the same value. Pass mode never overflows.
- DONE: out_valid = 1. first_nr, second_nr, operation and ovf_* hold stable. DONE → IDLE on out_ready.
- in_valid is ignored outside IDLE. No same-cycle accept on the DONE→IDLE edge.
- Output registers change only on entry to DONE or on reset. Working registers are internal and never visible.

## Timing
- Reset values: first_nr = 0, second_nr = 0, operation = 0, ovf_a = 0, ovf_b = 0, out_valid = 0, busy = 0, in_ready = 0 while rst is high. State returns to IDLE.
- Latency: the accepting edge is E0; out_valid is high after edge E0+N (N = W/CHUNK).
- Throughput: at most one word per N+2 cycles (N CONV, ≥1 DONE, 1 IDLE).
- Back-pressure: DONE persists indefinitely while out_ready = 0, with outputs stable. in_ready goes high the cycle after the out_valid & out_ready edge.
- Reset mid-CONV or mid-DONE: the operation is abandoned and outputs return to their reset values on that edge. in_ready is high the first cycle rst is low.
- rst has priority over any handshake on the same edge.
- Illegal parameters (W % CHUNK != 0, or W < 2) stop elaboration with $error.

## Configuration
- OPERAND_NEGATE_SATURATE_EN defined: on overflow the result is the most-positive value (0 followed by W-1 ones); ovf_* is still set.
- Undefined: overflow result wraps (equals the input); ovf_* is set.
- All other behaviour is identical in both builds.

## Test plan
- W=8, CHUNK=2: nr_coded = {8'h05, 8'h03, 4'hA}, modes 01/01 → first_nr = 8'hFB, second_nr = 8'hFD, operation = 4'hA, ovf = 0/0, out_valid 4 cycles after accept.
- Absolute mode: {8'hF6, 8'h0A, 4'h3}, modes 10/10 → 8'h0A/8'h0A, ovf = 0/0. Modes 11/00 → 8'hF6/8'h0A unchanged.
- Overflow: {8'h80, 8'h00, 4'h1}, modes 01/01 → without macro first_nr = 8'h80, ovf_a = 1, second_nr = 8'h00, ovf_b = 0. With macro first_nr = 8'h7F, ovf_a = 1.
- Back-pressure: out_ready low for 5 cycles after out_valid, in_valid held high with a new word → outputs stable, in_ready = 0, new word not taken. The edge after out_ready is raised → in_ready = 1 and the new word is accepted.
- Reset in the 2nd CONV cycle → next edge out_valid = 0, busy = 0, all outputs 0. A fresh word afterwards converts correctly with no leftover carry.
- W=16, CHUNK=16: {16'h0001, 16'h8000, 4'hF}, modes 01/10 → 16'hFFFF / 16'h8000 (ovf_b = 1), latency 1 cycle.

Source files
------------

// File: rtl/operand_negate_unit_if.sv
// operand_negate_unit_if: coded-word input and converted-result output handshakes.
// The unit itself connects through the slave modport.
interface operand_negate_unit_if #(
    parameter int W     = 8,
    parameter int OPC_W = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [2*W+OPC_W-1:0]   nr_coded;
    logic [1:0]             mode_a;
    logic [1:0]             mode_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [W-1:0]           first_nr;
    logic [W-1:0]           second_nr;
    logic [OPC_W-1:0]       operation;
    logic                   ovf_a;
    logic                   ovf_b;
    modport master (
        output in_valid, nr_coded, mode_a, mode_b, out_ready,
        input  in_ready, out_valid, first_nr, second_nr, operation, ovf_a, ovf_b
    );
    modport slave (
        input  in_valid, nr_coded, mode_a, mode_b, out_ready,
        output in_ready, out_valid, first_nr, second_nr, operation, ovf_a, ovf_b
    );
endinterface

// File: rtl/operand_negate_unit.sv
// operand_negate_unit: chunk-serial pass/negate/abs of two operands with overflow flags.
// OPERAND_NEGATE_SATURATE_EN: overflowing results saturate to the most-positive value.
module operand_negate_unit #(
    parameter int W     = 8,
    parameter int OPC_W = 4,
    parameter int CHUNK = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    operand_negate_unit_if.slave    bus,
    output logic                    busy
);
    localparam int N  = W / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [W-1:0]  MIN  = {1'b1, {(W-1){1'b0}}};
`ifdef OPERAND_NEGATE_SATURATE_EN
    localparam logic [W-1:0]  MAX  = {1'b0, {(W-1){1'b1}}};
`endif

    if (W < 2 || (W % CHUNK) != 0) begin : g_bad_param
        $error("operand_negate_unit: W must be >= 2 and a multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      a_q, a_d, b_q, b_d;
    logic [OPC_W-1:0]  opc_q, opc_d;
    logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic              cy_a_q, cy_a_d, cy_b_q, cy_b_d;
    logic              wov_a_q, wov_a_d, wov_b_q, wov_b_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [W-1:0]      first_q, first_d, second_q, second_d;
    logic [OPC_W-1:0]  op_q, op_d;
    logic              ovf_a_q, ovf_a_d, ovf_b_q, ovf_b_d;
    logic [CHUNK:0]    sum_a, sum_b;
    logic [CHUNK-1:0]  conv_a, conv_b;
    logic [W-1:0]      in_a, in_b, shf_a, shf_b;
    logic              ni_a, ni_b;

    assign in_a = bus.nr_coded[2*W+OPC_W-1 -: W];
    assign in_b = bus.nr_coded[W+OPC_W-1 -: W];
    assign ni_a = (bus.mode_a == 2'b01) | ((bus.mode_a == 2'b10) & in_a[W-1]);
    assign ni_b = (bus.mode_b == 2'b01) | ((bus.mode_b == 2'b10) & in_b[W-1]);

    // Converted LSB chunk enters at the top, so after N shifts the word is back in order.
    assign sum_a  = {1'b0, ~a_q[CHUNK-1:0]} + (CHUNK+1)'(cy_a_q);
    assign sum_b  = {1'b0, ~b_q[CHUNK-1:0]} + (CHUNK+1)'(cy_b_q);
    assign conv_a = neg_a_q ? sum_a[CHUNK-1:0] : a_q[CHUNK-1:0];
    assign conv_b = neg_b_q ? sum_b[CHUNK-1:0] : b_q[CHUNK-1:0];
    assign shf_a  = (a_q >> CHUNK) | (W'(conv_a) << (W - CHUNK));
    assign shf_b  = (b_q >> CHUNK) | (W'(conv_b) << (W - CHUNK));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        opc_d    = opc_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        cy_a_d   = cy_a_q;
        cy_b_d   = cy_b_q;
        wov_a_d  = wov_a_q;
        wov_b_d  = wov_b_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        second_d = second_q;
        op_d     = op_q;
        ovf_a_d  = ovf_a_q;
        ovf_b_d  = ovf_b_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                state_d = CONV;
                a_d     = in_a;
                b_d     = in_b;
                opc_d   = bus.nr_coded[OPC_W-1:0];
                neg_a_d = ni_a;
                neg_b_d = ni_b;
                cy_a_d  = 1'b1;
                cy_b_d  = 1'b1;
                wov_a_d = ni_a & (in_a == MIN);
                wov_b_d = ni_b & (in_b == MIN);
                cnt_d   = '0;
            end
            CONV: begin
                a_d    = shf_a;
                b_d    = shf_b;
                cy_a_d = sum_a[CHUNK];
                cy_b_d = sum_b[CHUNK];
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d  = DONE;
`ifdef OPERAND_NEGATE_SATURATE_EN
                    first_d  = wov_a_q ? MAX : shf_a;
                    second_d = wov_b_q ? MAX : shf_b;
`else
                    first_d  = shf_a;
                    second_d = shf_b;
`endif
                    op_d     = opc_q;
                    ovf_a_d  = wov_a_q;
                    ovf_b_d  = wov_b_q;
                end
            end
            DONE: state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            opc_q    <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            cy_a_q   <= 1'b0;
            cy_b_q   <= 1'b0;
            wov_a_q  <= 1'b0;
            wov_b_q  <= 1'b0;
            cnt_q    <= '0;
            first_q  <= '0;
            second_q <= '0;
            op_q     <= '0;
            ovf_a_q  <= 1'b0;
            ovf_b_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opc_q    <= opc_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            cy_a_q   <= cy_a_d;
            cy_b_q   <= cy_b_d;
            wov_a_q  <= wov_a_d;
            wov_b_q  <= wov_b_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            second_q <= second_d;
            op_q     <= op_d;
            ovf_a_q  <= ovf_a_d;
            ovf_b_q  <= ovf_b_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) & ~rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.first_nr  = first_q;
    assign bus.second_nr = second_q;
    assign bus.operation = op_q;
    assign bus.ovf_a     = ovf_a_q;
    assign bus.ovf_b     = ovf_b_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_operand_negate_unit.sv
// tb_operand_negate_unit: directed vectors for the W=8/CHUNK=2 and W=16/CHUNK=16 builds.
module tb_operand_negate_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy8, busy16;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    operand_negate_unit_if #(.W(8),  .OPC_W(4)) b8 ();
    operand_negate_unit_if #(.W(16), .OPC_W(4)) b16 ();

    operand_negate_unit #(.W(8),  .OPC_W(4), .CHUNK(2))  u8  (.clk(clk), .rst(rst), .bus(b8),  .busy(busy8));
    operand_negate_unit #(.W(16), .OPC_W(4), .CHUNK(16)) u16 (.clk(clk), .rst(rst), .bus(b16), .busy(busy16));

`ifdef OPERAND_NEGATE_SATURATE_EN
    localparam logic [7:0]  OV8  = 8'h7F;
    localparam logic [15:0] OV16 = 16'h7FFF;
`else
    localparam logic [7:0]  OV8  = 8'h80;
    localparam logic [15:0] OV16 = 16'h8000;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start8(input logic [19:0] w, input logic [1:0] ma, input logic [1:0] mb);
        b8.nr_coded = w;
        b8.mode_a   = ma;
        b8.mode_b   = mb;
        b8.in_valid = 1'b1;
        check("accept_ready", b8.in_ready, 1);
        tick;
        b8.in_valid = 1'b0;
    endtask

    task automatic wait8(input string tag);
        int lat = 0;
        while (!b8.out_valid && lat < 20) begin
            tick;
            lat++;
        end
        check({tag, "_latency"}, lat, 4);
    endtask

    task automatic expect8(input string tag, input logic [7:0] f, input logic [7:0] s,
                           input logic [3:0] op, input logic oa, input logic ob);
        check({tag, "_first"},  b8.first_nr,  f);
        check({tag, "_second"}, b8.second_nr, s);
        check({tag, "_op"},     b8.operation, op);
        check({tag, "_ovf_a"},  b8.ovf_a,     oa);
        check({tag, "_ovf_b"},  b8.ovf_b,     ob);
    endtask

    task automatic release8(input string tag);
        b8.out_ready = 1'b1;
        tick;
        b8.out_ready = 1'b0;
        check({tag, "_idle_ready"}, b8.in_ready, 1);
        check({tag, "_idle_valid"}, b8.out_valid, 0);
    endtask

    task automatic xfer8(input string tag, input logic [19:0] w, input logic [1:0] ma, input logic [1:0] mb,
                         input logic [7:0] f, input logic [7:0] s, input logic oa, input logic ob);
        start8(w, ma, mb);
        wait8(tag);
        expect8(tag, f, s, w[3:0], oa, ob);
        release8(tag);
    endtask

    initial begin
        b8.in_valid = 0;  b8.out_ready = 0;  b8.nr_coded = '0;  b8.mode_a = 0;  b8.mode_b = 0;
        b16.in_valid = 0; b16.out_ready = 0; b16.nr_coded = '0; b16.mode_a = 0; b16.mode_b = 0;
        tick;
        tick;
        check("rst_in_ready", b8.in_ready, 0);
        check("rst_out_valid", b8.out_valid, 0);
        check("rst_busy", busy8, 0);
        expect8("rst", 8'h00, 8'h00, 4'h0, 0, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", b8.in_ready, 1);

        xfer8("neg",     {8'h05, 8'h03, 4'hA}, 2'b01, 2'b01, 8'hFB, 8'hFD, 0, 0);
        xfer8("abs",     {8'hF6, 8'h0A, 4'h3}, 2'b10, 2'b10, 8'h0A, 8'h0A, 0, 0);
        xfer8("pass",    {8'hF6, 8'h0A, 4'h3}, 2'b11, 2'b00, 8'hF6, 8'h0A, 0, 0);
        xfer8("ovf",     {8'h80, 8'h00, 4'h1}, 2'b01, 2'b01, OV8,   8'h00, 1, 0);
        xfer8("ovf_abs", {8'h80, 8'h80, 4'h2}, 2'b00, 2'b10, 8'h80, OV8,   0, 1);
        xfer8("mix",     {8'h7F, 8'h01, 4'h5}, 2'b10, 2'b01, 8'h7F, 8'hFF, 0, 0);

        // back-pressure with a competing word held on the input
        start8({8'h05, 8'h03, 4'hA}, 2'b01, 2'b01);
        wait8("bp");
        b8.nr_coded = {8'h11, 8'h22, 4'h4};
        b8.mode_a   = 2'b01;
        b8.mode_b   = 2'b00;
        b8.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", b8.out_valid, 1);
            check("bp_in_ready", b8.in_ready, 0);
            check("bp_first", b8.first_nr, 8'hFB);
            check("bp_second", b8.second_nr, 8'hFD);
            tick;
        end
        expect8("bp_hold", 8'hFB, 8'hFD, 4'hA, 0, 0);
        b8.out_ready = 1'b1;
        tick;
        b8.out_ready = 1'b0;
        check("bp_release_ready", b8.in_ready, 1);
        check("bp_release_valid", b8.out_valid, 0);
        tick;
        b8.in_valid = 1'b0;
        check("bp_accept_busy", busy8, 1);
        wait8("bp_new");
        expect8("bp_new", 8'hEF, 8'h22, 4'h4, 0, 0);
        release8("bp_new");

        // reset during the second conversion cycle
        start8({8'h05, 8'h03, 4'hA}, 2'b01, 2'b01);
        tick;
        rst = 1'b1;
        tick;
        check("mid_rst_valid", b8.out_valid, 0);
        check("mid_rst_busy", busy8, 0);
        check("mid_rst_ready", b8.in_ready, 0);
        expect8("mid_rst", 8'h00, 8'h00, 4'h0, 0, 0);
        rst = 1'b0;
        #1;
        check("mid_rst_free_ready", b8.in_ready, 1);
        xfer8("fresh", {8'h00, 8'h01, 4'h7}, 2'b01, 2'b01, 8'h00, 8'hFF, 0, 0);

        // single-chunk build: one conversion cycle
        b16.nr_coded = {16'h0001, 16'h8000, 4'hF};
        b16.mode_a   = 2'b01;
        b16.mode_b   = 2'b10;
        b16.in_valid = 1'b1;
        check("w16_ready", b16.in_ready, 1);
        tick;
        b16.in_valid = 1'b0;
        check("w16_pre_valid", b16.out_valid, 0);
        tick;
        check("w16_valid", b16.out_valid, 1);
        check("w16_first", b16.first_nr, 16'hFFFF);
        check("w16_second", b16.second_nr, OV16);
        check("w16_op", b16.operation, 4'hF);
        check("w16_ovf_a", b16.ovf_a, 0);
        check("w16_ovf_b", b16.ovf_b, 1);
        b16.out_ready = 1'b1;
        tick;
        b16.out_ready = 1'b0;
        check("w16_idle", busy16, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
